// File: rtl/commit_rob.sv
// Reorder buffer with in-order, one-per-cycle retirement feeding rename.
// A mispredicted branch at the head retires, flushes the buffer and flips the epoch.
module commit_rob #(
  parameter int NUM_ARCH_REG = 8,
  parameter int NUM_PHYS_REG = 32,
  parameter int ROB_DEPTH    = 16,
  localparam int AW = $clog2(NUM_ARCH_REG),
  localparam int PW = $clog2(NUM_PHYS_REG),
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int TW = IW + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             alloc_v_i,
  output logic             alloc_ready_o,
  input  logic             alloc_w_v_i,
  input  logic [AW-1:0]    alloc_arch_dest_i,
  input  logic [PW-1:0]    alloc_freed_reg_i,
  input  logic             alloc_is_branch_i,
  output logic [TW-1:0]    alloc_tag_o,
  input  logic             cmpl_v_i,
  input  logic [TW-1:0]    cmpl_tag_i,
  input  logic             cmpl_mispredict_i,
  output logic             commit_v_o,
  output logic [AW+PW:0]   commit_rename_o,
  output logic             mispredict_o
);

  localparam logic [IW:0] FULL_COUNT = (IW+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_vec;
  logic [ROB_DEPTH-1:0] done_vec;
  logic [ROB_DEPTH-1:0] mispredict_vec;

  logic [ROB_DEPTH-1:0] w_v_mem;
  logic [ROB_DEPTH-1:0] is_branch_mem;
  logic [AW-1:0]        arch_dest_mem [ROB_DEPTH];
  logic [PW-1:0]        freed_reg_mem [ROB_DEPTH];

  logic [IW-1:0] head_reg;
  logic [IW-1:0] tail_reg;
  logic [IW:0]   count_reg;
  logic          epoch_reg;

  logic          do_alloc;
  logic          do_commit;
  logic          flush;
  logic          cmpl_accept;
  logic [IW-1:0] cmpl_idx;

  assign cmpl_idx  = cmpl_tag_i[IW-1:0];

  // Stale done bits on free slots are masked by the occupancy check.
  assign do_commit = reset_n_i && (count_reg != '0) && done_vec[head_reg];
  assign flush     = do_commit && is_branch_mem[head_reg] && mispredict_vec[head_reg];

  assign commit_v_o      = do_commit;
  assign mispredict_o    = flush;
  assign commit_rename_o = do_commit ?
                           {w_v_mem[head_reg], arch_dest_mem[head_reg], freed_reg_mem[head_reg]} :
                           '0;

  assign alloc_ready_o = reset_n_i && (count_reg != FULL_COUNT) && !flush;
  assign do_alloc      = alloc_v_i && alloc_ready_o;
  assign alloc_tag_o   = reset_n_i ? {epoch_reg, tail_reg} : '0;

  // Completions from an older epoch or to free slots are dropped.
  assign cmpl_accept = cmpl_v_i && !flush && (cmpl_tag_i[IW] == epoch_reg) && valid_vec[cmpl_idx];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      epoch_reg <= 1'b0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      epoch_reg <= ~epoch_reg;
    end else begin
      if (do_alloc) begin
        tail_reg <= tail_reg + IW'(1);
      end
      if (do_commit) begin
        head_reg <= head_reg + IW'(1);
      end
      case ({do_alloc, do_commit})
        2'b10:   count_reg <= count_reg + (IW+1)'(1);
        2'b01:   count_reg <= count_reg - (IW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      w_v_mem[tail_reg]       <= alloc_w_v_i;
      is_branch_mem[tail_reg] <= alloc_is_branch_i;
      arch_dest_mem[tail_reg] <= alloc_arch_dest_i;
      freed_reg_mem[tail_reg] <= alloc_freed_reg_i;
    end
  end

  generate
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      logic valid_reg;
      logic done_reg;
      logic mispredict_reg;
      logic alloc_hit;
      logic cmpl_hit;
      logic commit_hit;

      assign alloc_hit  = do_alloc && (tail_reg == IW'(gi));
      assign cmpl_hit   = cmpl_accept && (cmpl_idx == IW'(gi));
      assign commit_hit = do_commit && (head_reg == IW'(gi));

      always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush) begin
          valid_reg      <= 1'b0;
          done_reg       <= 1'b0;
          mispredict_reg <= 1'b0;
        end else if (alloc_hit) begin
          valid_reg      <= 1'b1;
          done_reg       <= 1'b0;
          mispredict_reg <= 1'b0;
        end else begin
          if (commit_hit) begin
            valid_reg <= 1'b0;
          end
          if (cmpl_hit) begin
            done_reg       <= 1'b1;
            mispredict_reg <= mispredict_reg | cmpl_mispredict_i;
          end
        end
      end

      assign valid_vec[gi]      = valid_reg;
      assign done_vec[gi]       = done_reg;
      assign mispredict_vec[gi] = mispredict_reg;
    end
  endgenerate

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: expected retirements are queued at allocation
// and checked in order by a negedge monitor as the DUT commits them.
module tb_commit_rob;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       alloc_v_i;
  logic       alloc_ready_o;
  logic       alloc_w_v_i;
  logic [2:0] alloc_arch_dest_i;
  logic [4:0] alloc_freed_reg_i;
  logic       alloc_is_branch_i;
  logic [4:0] alloc_tag_o;
  logic       cmpl_v_i;
  logic [4:0] cmpl_tag_i;
  logic       cmpl_mispredict_i;
  logic       commit_v_o;
  logic [8:0] commit_rename_o;
  logic       mispredict_o;

  typedef struct packed {
    logic [8:0] ren;
    logic       mis;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic       m_epoch;
  logic [3:0] m_tail;
  logic [4:0] tags [16];
  logic [4:0] wtag [40];
  logic [4:0] t;

  always #5 clk_i = ~clk_i;

  commit_rob #(
    .NUM_ARCH_REG(8),
    .NUM_PHYS_REG(32),
    .ROB_DEPTH(16)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .alloc_v_i(alloc_v_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_w_v_i(alloc_w_v_i),
    .alloc_arch_dest_i(alloc_arch_dest_i),
    .alloc_freed_reg_i(alloc_freed_reg_i),
    .alloc_is_branch_i(alloc_is_branch_i),
    .alloc_tag_o(alloc_tag_o),
    .cmpl_v_i(cmpl_v_i),
    .cmpl_tag_i(cmpl_tag_i),
    .cmpl_mispredict_i(cmpl_mispredict_i),
    .commit_v_o(commit_v_o),
    .commit_rename_o(commit_rename_o),
    .mispredict_o(mispredict_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic wv, input logic [2:0] arch, input logic [4:0] freed,
                       input logic br, input logic mis, output logic [4:0] tag);
    alloc_v_i         = 1'b1;
    alloc_w_v_i       = wv;
    alloc_arch_dest_i = arch;
    alloc_freed_reg_i = freed;
    alloc_is_branch_i = br;
    check("alloc_ready", alloc_ready_o, 1);
    check("alloc_tag", alloc_tag_o, {m_epoch, m_tail});
    tag = {m_epoch, m_tail};
    exp_q.push_back('{ren: {wv, arch, freed}, mis: mis});
    $display("alloc tag=%0h wv=%0b arch=%0d freed=%0d br=%0b", tag, wv, arch, freed, br);
    m_tail = m_tail + 4'd1;
    tick();
    alloc_v_i = 1'b0;
  endtask

  task automatic complete(input logic [4:0] tag, input logic mis);
    cmpl_v_i          = 1'b1;
    cmpl_tag_i        = tag;
    cmpl_mispredict_i = mis;
    $display("complete tag=%0h mispredict=%0b", tag, mis);
    tick();
    cmpl_v_i          = 1'b0;
    cmpl_mispredict_i = 1'b0;
  endtask

  // Retirement monitor: every commit must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1) begin
      if (commit_v_o === 1'b1) begin
        check("commit_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          $display("commit rename=%03h mispredict=%0b", commit_rename_o, mispredict_o);
          check("commit_rename", commit_rename_o, mon_e.ren);
          check("commit_mispredict", mispredict_o, mon_e.mis);
        end
      end else begin
        check("idle_rename", commit_rename_o, 0);
        check("idle_mispredict", mispredict_o, 0);
      end
    end
  end

  initial begin
    reset_n_i         = 1'b0;
    alloc_v_i         = 1'b0;
    alloc_w_v_i       = 1'b0;
    alloc_arch_dest_i = '0;
    alloc_freed_reg_i = '0;
    alloc_is_branch_i = 1'b0;
    cmpl_v_i          = 1'b0;
    cmpl_tag_i        = '0;
    cmpl_mispredict_i = 1'b0;
    m_epoch           = 1'b0;
    m_tail            = '0;

    // Reset held for two cycles
    tick();
    check("rst_alloc_ready", alloc_ready_o, 0);
    check("rst_commit_v", commit_v_o, 0);
    check("rst_commit_rename", commit_rename_o, 0);
    check("rst_alloc_tag", alloc_tag_o, 0);
    tick();
    check("rst2_alloc_ready", alloc_ready_o, 0);
    reset_n_i = 1'b1;
    #1;
    check("post_rst_ready", alloc_ready_o, 1);
    check("post_rst_tag", alloc_tag_o, 5'h00);

    // In-order retirement of out-of-order completions
    alloc(1'b1, 3'd3, 5'd8, 1'b0, 1'b0, t);
    alloc(1'b1, 3'd4, 5'd9, 1'b0, 1'b0, t);
    alloc(1'b1, 3'd5, 5'd10, 1'b0, 1'b0, t);
    check("inorder_q_ren0", exp_q[0].ren, 9'h168);
    check("inorder_q_ren1", exp_q[1].ren, 9'h189);
    check("inorder_q_ren2", exp_q[2].ren, 9'h1AA);
    complete(5'h02, 1'b0);
    check("inorder_wait2", commit_v_o, 0);
    complete(5'h01, 1'b0);
    check("inorder_wait1", commit_v_o, 0);
    complete(5'h00, 1'b0);
    check("inorder_c0", commit_v_o, 1);
    tick();
    check("inorder_c1", commit_v_o, 1);
    tick();
    check("inorder_c2", commit_v_o, 1);
    tick();
    check("inorder_done", commit_v_o, 0);
    check("inorder_q_empty", exp_q.size(), 0);

    // Full buffer
    for (int i = 0; i < 16; i++) begin
      alloc(1'(i), 3'(i), 5'(i + 16), 1'b0, 1'b0, tags[i]);
    end
    check("full_not_ready", alloc_ready_o, 0);
    alloc_v_i = 1'b1;
    tick();
    alloc_v_i = 1'b0;
    check("full_alloc_ignored_tag", alloc_tag_o, {m_epoch, m_tail});
    check("full_still_not_ready", alloc_ready_o, 0);
    complete(tags[0], 1'b0);
    check("full_commit_v", commit_v_o, 1);
    check("full_ready_during_commit", alloc_ready_o, 0);
    tick();
    check("full_ready_after_commit", alloc_ready_o, 1);
    for (int i = 1; i < 16; i++) begin
      complete(tags[i], 1'b0);
    end
    tick();
    tick();
    check("full_drained", commit_v_o, 0);
    check("full_q_empty", exp_q.size(), 0);

    // Reset mid-operation discards live entries
    alloc(1'b1, 3'd1, 5'd1, 1'b0, 1'b0, tags[0]);
    alloc(1'b1, 3'd2, 5'd2, 1'b0, 1'b0, tags[1]);
    exp_q.delete();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    m_tail    = '0;
    m_epoch   = 1'b0;
    #1;
    check("midrst_ready", alloc_ready_o, 1);
    check("midrst_tag", alloc_tag_o, 5'h00);
    complete(tags[0], 1'b0);
    complete(tags[1], 1'b0);
    check("midrst_no_commit", commit_v_o, 0);
    tick();
    check("midrst_no_commit2", commit_v_o, 0);

    // Mispredict flush
    alloc(1'b0, 3'd1, 5'd2, 1'b1, 1'b1, t);
    alloc(1'b1, 3'd6, 5'd11, 1'b0, 1'b0, t);
    alloc(1'b1, 3'd7, 5'd12, 1'b0, 1'b0, t);
    complete(5'h01, 1'b0);
    complete(5'h02, 1'b0);
    check("flush_wait", commit_v_o, 0);
    complete(5'h00, 1'b1);
    check("flush_commit_v", commit_v_o, 1);
    check("flush_mispredict", mispredict_o, 1);
    check("flush_ready", alloc_ready_o, 0);
    alloc_v_i  = 1'b1;
    cmpl_v_i   = 1'b1;
    cmpl_tag_i = 5'h03;
    tick();
    alloc_v_i = 1'b0;
    cmpl_v_i  = 1'b0;
    check("flush_leftover", exp_q.size(), 2);
    exp_q.delete();
    m_epoch = 1'b1;
    m_tail  = '0;
    check("flush_tag", alloc_tag_o, 5'h10);
    check("flush_after_commit_v", commit_v_o, 0);
    check("flush_after_ready", alloc_ready_o, 1);
    tick();
    check("flush_no_more_commits", commit_v_o, 0);

    // Stale completion from the old epoch
    alloc(1'b1, 3'd2, 5'd3, 1'b0, 1'b0, t);
    complete(5'h00, 1'b0);
    check("stale_dropped", commit_v_o, 0);
    tick();
    check("stale_dropped2", commit_v_o, 0);
    complete(5'h10, 1'b0);
    check("stale_valid_commit", commit_v_o, 1);
    tick();
    check("stale_done", commit_v_o, 0);

    // Back-to-back pipeline across the wrap point
    for (int i = 0; i < 42; i++) begin
      if (i < 40) begin
        alloc_v_i         = 1'b1;
        alloc_w_v_i       = 1'b1;
        alloc_arch_dest_i = 3'(i);
        alloc_freed_reg_i = 5'(i);
        alloc_is_branch_i = 1'b0;
        check("wrap_ready", alloc_ready_o, 1);
        check("wrap_tag", alloc_tag_o, {m_epoch, m_tail});
        wtag[i] = {m_epoch, m_tail};
        exp_q.push_back('{ren: {1'b1, 3'(i), 5'(i)}, mis: 1'b0});
        $display("alloc tag=%0h arch=%0d freed=%0d", wtag[i], i % 8, i % 32);
        m_tail = m_tail + 4'd1;
      end else begin
        alloc_v_i = 1'b0;
      end
      if (i >= 1 && i <= 40) begin
        cmpl_v_i   = 1'b1;
        cmpl_tag_i = wtag[i-1];
      end else begin
        cmpl_v_i = 1'b0;
      end
      check("wrap_commit_v", commit_v_o, (i >= 2));
      tick();
    end
    alloc_v_i = 1'b0;
    cmpl_v_i  = 1'b0;
    check("wrap_idle", commit_v_o, 0);
    check("wrap_q_empty", exp_q.size(), 0);
    check("wrap_final_tag", alloc_tag_o, 5'h19);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
